bfp_frame_normalizer_2048mmax_16iw: RTL
=======================================

// Module: bfp_frame_normalizer_2048Mmax_16iw
// PURPOSE
//  Block-floating-point encoder placed upstream of the exponent shifter; the exponent shifter consumes its stream.
//  - Buffers each FFT frame of complex 16-bit I/Q in ping-pong banks and finds the frame's minimum redundant-sign-bit count.
//  - Left-shifts the whole frame by one common amount, keeping HEAD_ROOM bits spare.
//  - Emits the frame with bin index, block exponent and end-of-block flag in tuser.
// PARAMETERS
//  HEAD_ROOM   2    spare sign bits kept after normalisation (0..15)
//  MAX_SHIFT   15   upper clamp on applied shift (must be <=15)
//  ADDR_WIDTH  11   log2 of max frame length (2048)
// PORTS
//  clk            in   1   single clock
//  sync_reset     in   1   synchronous, active-high reset
//  s_axis_tvalid  in   1   input sample valid
//  s_axis_tdata   in   32  {I[15:0], Q[15:0]} two's complement
//  s_axis_tlast   in   1   last sample of frame
//  s_axis_tready  out  1   input accept
//  fft_size       in   12  frame length N, 8..2048, latched at frame start
//  frame_err      out  1   1-cycle pulse: tlast position != N
//  m_axis_tvalid  out  1   output valid
//  m_axis_tdata   out  32  {I<<<shift, Q<<<shift}
//  m_axis_tuser   out  24  [10:0] bin, [20:16] shift, [23] eob(=tlast), others 0
//  m_axis_tlast   out  1   last bin of frame
//  m_axis_tready  in   1   output accept
// BEHAVIOUR
//  - Reset: all outputs 0; both banks EMPTY; write/read pointers 0; s_axis_tready goes 1 in the cycle after reset deasserts.
//  - Bank states: EMPTY -> FILLING (first input take) -> FULL (frame closed, shift latched) -> DRAINING (first read) -> EMPTY (last output accepted).
//  - Write side alternates banks. s_axis_tready=0 when the next write bank is not EMPTY.
//  - Per sample, rsb(x) = count of leading bits equal to bit15, minus 1 (0x0000 and 0xFFFF -> 15; 0x8000 -> 0).
//    The frame minimum is taken over both I and Q.
//  - shift = clamp(min_rsb - HEAD_ROOM, 0, MAX_SHIFT); 5-bit unsigned. All-zero frame -> 15-HEAD_ROOM. Left shift never overflows.
//  - Frame close: on the earlier of an accepted tlast or an accepted sample with count==N-1.
//    - tlast before count N-1 (short frame): frame_err pulses; length = count+1.
//    - count reaches N-1 with no tlast: frame_err pulses; the frame closes anyway.
//  - Read side: bin counts 0..len-1; m_axis_tlast and tuser[23] are set on bin len-1.
//  - Latency: with the read side idle, m_axis_tvalid rises within 4 cycles after the tlast-accept edge (RAM read plus shift register).
//  - Handshake: AXI-stream rules; 2-entry output skid buffer. tdata/tuser are held stable while tvalid=1 and tready=0.
//    Back-to-back frames stream with no bubble while tready=1.
//  - Simultaneous events: a bank going EMPTY and a write to that bank starting in the same cycle is legal.
//    The freed bank is immediately available to the writer.
//  - fft_size changes mid-frame are ignored until the next frame start.
//  - sync_reset mid-frame discards all buffered data; partial output frames are not completed.
// CONFIGURATION
//  BFP_PEAK_OUT_EN defined:
//    - adds peak_mag[15:0] out: max |I| or |Q| of the closed frame, 0x8000 reported as 0x8000.
//    - adds peak_valid out: 1-cycle pulse coincident with shift latch.
//  BFP_PEAK_OUT_EN undefined: ports and logic absent; behaviour otherwise identical.
// STRUCTURE
//  - Shared package bfp_pkg: TUSER_BIN_LSB=0, TUSER_BIN_W=11, TUSER_EXP_LSB=16, TUSER_EXP_W=5, TUSER_EOB_BIT=23;
//    bank_state_t enum {EMPTY, FILLING, FULL, DRAINING}.
//    The exponent shifter uses the same constants.
//  - Sub-module bfp_pingpong_ram: 2x2^ADDR_WIDTH x 32 simple dual-port RAM, 1-cycle registered read.
//  - rsb count, min tracking, state machines and skid buffer live in this module.
// TESTING
//  1. N=8; I0=0x0100, all other samples 0x0010, tready=1.
//     -> shift=4, out I0=0x1000, others 0x0100; tuser[20:16]=4; bins 0..7; tlast and tuser[23] on bin 7.
//  2. N=8, all samples 0 -> shift=13, data 0, frame_err=0.
//  3. N=8 with one Q=0x8000 -> shift=0, output equals input bit-exact.
//  4. tready=0 while 3 frames of N=16 are offered -> first two accepted, s_axis_tready=0 on third.
//     Release tready -> 48 outputs in order, no bubble.
//  5. N=8, tlast on 6th sample -> frame_err pulse, 6 outputs with tlast on bin 5; next frame is full 8 bins.
//  6. sync_reset asserted mid-drain -> next cycle m_axis_tvalid=0; new frame after reset starts at bin 0.

Source files
------------

// File: rtl/bfp_pkg.sv
// Shared block-floating-point constants: tuser field layout, ping-pong bank states
// and the redundant-sign-bit counter. The exponent shifter uses the same layout.
package bfp_pkg;

  localparam int TUSER_BIN_LSB = 0;
  localparam int TUSER_BIN_W   = 11;
  localparam int TUSER_EXP_LSB = 16;
  localparam int TUSER_EXP_W   = 5;
  localparam int TUSER_EOB_BIT = 23;
  localparam int TUSER_W       = 24;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  // Leading bits equal to the sign bit, minus one: 0x0000/0xFFFF -> 15, 0x8000 -> 0.
  function automatic logic [3:0] rsb16(input logic [15:0] x);
    logic [3:0] r;
    logic       stop;
    r    = '0;
    stop = 1'b0;
    for (int i = 14; i >= 0; i--) begin
      if (!stop && (x[i] == x[15])) r = r + 4'd1;
      else stop = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bfp_pingpong_ram.sv
// Two frame banks in one simple dual-port RAM; the bank is the address MSB.
// One write port, one read port with a single registered read stage.
module bfp_pingpong_ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [0:(2**(ADDR_WIDTH+1))-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bfp_frame_normalizer_2048mmax_16iw.sv
// Block-floating-point frame normaliser: buffers a frame, finds its common shift and
// replays it left-shifted with bin/exponent/eob in tuser. BFP_PEAK_OUT_EN adds peak_mag/peak_valid.
module bfp_frame_normalizer_2048mmax_16iw
  import bfp_pkg::*;
#(
  parameter int HEAD_ROOM  = 2,
  parameter int MAX_SHIFT  = 15,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic                 s_axis_tvalid,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  input  logic [ADDR_WIDTH:0]  fft_size,
  output logic                 frame_err,
  output logic                 m_axis_tvalid,
  output logic [31:0]          m_axis_tdata,
  output logic [TUSER_W-1:0]   m_axis_tuser,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready
`ifdef BFP_PEAK_OUT_EN
  ,
  output logic [15:0]          peak_mag,
  output logic                 peak_valid
`endif
);

  localparam int LEN_W = ADDR_WIDTH + 1;

  // Valid/ready: a beat transfers on a rising edge where valid and ready are both 1;
  // a source holding valid keeps data stable until that edge.

  bank_state_t           bank_state [2];
  logic [LEN_W-1:0]      bank_len   [2];
  logic [4:0]            bank_shift [2];

  logic                  ready_en;
  logic                  wr_bank;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [LEN_W-1:0]      len_q;
  logic [3:0]            min_rsb;

  logic                  rd_bank, rd_busy, out_bank;
  logic [ADDR_WIDTH-1:0] rd_bin;

  logic                  p1_valid, p1_last;
  logic [ADDR_WIDTH-1:0] p1_bin;
  logic [4:0]            p1_shift;
  logic [31:0]           ram_q;

  logic [31:0]           fq_data [2];
  logic [TUSER_W-1:0]    fq_user [2];
  logic                  fq_last [2];
  logic                  fq_wr, fq_rd;
  logic [1:0]            fq_cnt;

  logic                  pop, release_bank, wr_free, take, first, at_end, close, err;
  logic [LEN_W-1:0]      cur_len;
  logic [3:0]            rsb_i, rsb_q, samp_min, frame_min;
  logic [4:0]            new_shift;
  logic                  can_start, issue, issue_last;
  logic [2:0]            occ;
  logic [15:0]           sh_i, sh_q;
  logic [TUSER_W-1:0]    p1_user;

  // Write side and frame statistics
  always_comb begin
    int d;
    pop          = (fq_cnt != 2'd0) && m_axis_tready;
    release_bank = pop && fq_last[fq_rd];
    // A bank freed by the last output beat is writable in the same cycle.
    wr_free      = (bank_state[wr_bank] == EMPTY) || (bank_state[wr_bank] == FILLING) ||
                   (release_bank && (out_bank == wr_bank));
    s_axis_tready = ready_en && wr_free;
    take         = s_axis_tvalid && s_axis_tready;
    first        = (wr_cnt == '0);
    cur_len      = first ? fft_size : len_q;
    at_end       = ({1'b0, wr_cnt} == (cur_len - LEN_W'(1)));
    close        = take && (s_axis_tlast || at_end);
    err          = take && (s_axis_tlast != at_end);
    rsb_i        = rsb16(s_axis_tdata[31:16]);
    rsb_q        = rsb16(s_axis_tdata[15:0]);
    samp_min     = (rsb_i < rsb_q) ? rsb_i : rsb_q;
    frame_min    = (first || (samp_min < min_rsb)) ? samp_min : min_rsb;
    d            = int'(frame_min) - HEAD_ROOM;
    if (d < 0) d = 0;
    if (d > MAX_SHIFT) d = MAX_SHIFT;
    new_shift    = 5'(d);
  end

  // Read side: keep fifo entries plus in-flight RAM reads within the 2-entry buffer.
  always_comb begin
    can_start  = (bank_state[rd_bank] == FULL);
    occ        = 3'(fq_cnt) + 3'(p1_valid) - 3'(pop);
    issue      = (rd_busy || can_start) && (occ < 3'd2);
    issue_last = ({1'b0, rd_bin} == (bank_len[rd_bank] - LEN_W'(1)));
    sh_i       = ram_q[31:16] << p1_shift;
    sh_q       = ram_q[15:0] << p1_shift;
    p1_user    = '0;
    p1_user[TUSER_BIN_LSB +: TUSER_BIN_W] = p1_bin;
    p1_user[TUSER_EXP_LSB +: TUSER_EXP_W] = p1_shift;
    p1_user[TUSER_EOB_BIT]                = p1_last;
  end

  bfp_pingpong_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_W     (32)
  ) u_ram (
    .clk     (clk),
    .wr_en   (take),
    .wr_addr ({wr_bank, wr_cnt}),
    .wr_data (s_axis_tdata),
    .rd_en   (issue),
    .rd_addr ({rd_bank, rd_bin}),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      ready_en      <= 1'b0;
      bank_state[0] <= EMPTY;
      bank_state[1] <= EMPTY;
      bank_len[0]   <= '0;
      bank_len[1]   <= '0;
      bank_shift[0] <= '0;
      bank_shift[1] <= '0;
      wr_bank       <= 1'b0;
      wr_cnt        <= '0;
      len_q         <= '0;
      min_rsb       <= '0;
      frame_err     <= 1'b0;
      rd_bank       <= 1'b0;
      rd_busy       <= 1'b0;
      rd_bin        <= '0;
      out_bank      <= 1'b0;
      p1_valid      <= 1'b0;
      p1_last       <= 1'b0;
      p1_bin        <= '0;
      p1_shift      <= '0;
      fq_wr         <= 1'b0;
      fq_rd         <= 1'b0;
      fq_cnt        <= '0;
      fq_data[0]    <= '0;
      fq_data[1]    <= '0;
      fq_user[0]    <= '0;
      fq_user[1]    <= '0;
      fq_last[0]    <= 1'b0;
      fq_last[1]    <= 1'b0;
    end else begin
      ready_en  <= 1'b1;
      frame_err <= err;

      if (release_bank) begin
        bank_state[out_bank] <= EMPTY;
        out_bank             <= ~out_bank;
      end

      p1_valid <= issue;
      if (issue) begin
        p1_bin   <= rd_bin;
        p1_shift <= bank_shift[rd_bank];
        p1_last  <= issue_last;
        if (can_start) bank_state[rd_bank] <= DRAINING;
        if (issue_last) begin
          rd_bin  <= '0;
          rd_busy <= 1'b0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_bin  <= rd_bin + ADDR_WIDTH'(1);
          rd_busy <= 1'b1;
        end
      end

      // Placed after the release so a same-cycle refill of the freed bank wins.
      if (take) begin
        if (first) len_q <= fft_size;
        min_rsb <= frame_min;
        if (close) begin
          bank_state[wr_bank] <= FULL;
          bank_len[wr_bank]   <= {1'b0, wr_cnt} + LEN_W'(1);
          bank_shift[wr_bank] <= new_shift;
          wr_cnt              <= '0;
          wr_bank             <= ~wr_bank;
        end else begin
          bank_state[wr_bank] <= FILLING;
          wr_cnt              <= wr_cnt + ADDR_WIDTH'(1);
        end
      end

      if (p1_valid) begin
        fq_data[fq_wr] <= {sh_i, sh_q};
        fq_user[fq_wr] <= p1_user;
        fq_last[fq_wr] <= p1_last;
        fq_wr          <= ~fq_wr;
      end
      if (pop) fq_rd <= ~fq_rd;
      fq_cnt <= fq_cnt + 2'(p1_valid) - 2'(pop);
    end
  end

  assign m_axis_tvalid = (fq_cnt != 2'd0);
  assign m_axis_tdata  = fq_data[fq_rd];
  assign m_axis_tuser  = fq_user[fq_rd];
  assign m_axis_tlast  = fq_last[fq_rd];

`ifdef BFP_PEAK_OUT_EN
  logic [15:0] peak_run, abs_i, abs_q, samp_peak, frame_peak;

  // Magnitude of 0x8000 wraps to 0x8000, which is the intended report.
  always_comb begin
    abs_i      = s_axis_tdata[31] ? (~s_axis_tdata[31:16] + 16'd1) : s_axis_tdata[31:16];
    abs_q      = s_axis_tdata[15] ? (~s_axis_tdata[15:0] + 16'd1) : s_axis_tdata[15:0];
    samp_peak  = (abs_i > abs_q) ? abs_i : abs_q;
    frame_peak = (first || (samp_peak > peak_run)) ? samp_peak : peak_run;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      peak_run   <= '0;
      peak_mag   <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= close;
      if (take) peak_run <= frame_peak;
      if (close) peak_mag <= frame_peak;
    end
  end
`endif

endmodule
